// File: rtl/aline_capture_pkg.sv
// rtl/aline_capture_pkg.sv - shared types and constants for the A-line capture writer
package aline_capture_pkg;

    // Default memory geometry: 128000 32-bit words, 17-bit word address.
    localparam int DEPTH_WORDS = 128000;
    localparam int ADDR_W      = 17;

    // Byte-lane masks for a full sample pair and for a lone trailing sample.
    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/sample_pair_packer.sv
// rtl/sample_pair_packer.sv - packs 16-bit samples into 32-bit write words
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   accept         a sample is accepted into the current line this cycle
//   flush          emit the lone latched sample as a low-half-only word
//   sample_data    16-bit ADC sample
//   pair_odd       high when the low half is filled and the next sample completes a word
//   write          registered write strobe for the word on writedata
//   writedata      packed word; the first sample of a pair sits in [15:0]
//   byteenable     byte lanes valid in writedata
module sample_pair_packer
    import aline_capture_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic        flush,
    input  logic [15:0] sample_data,
    output logic        pair_odd,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable
);

    logic [15:0] low_half;

    // Every line ends with the toggle cleared (odd-index write or flush), so a
    // new line always starts on an even sample without an explicit clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_odd   <= 1'b0;
            low_half   <= 16'h0;
            write      <= 1'b0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
        end else begin
            write <= 1'b0;
            if (flush) begin
                writedata  <= {16'h0, low_half};
                byteenable <= BE_LOW;
                write      <= 1'b1;
                pair_odd   <= 1'b0;
            end else if (accept) begin
                if (pair_odd) begin
                    writedata  <= {sample_data, low_half};
                    byteenable <= BE_FULL;
                    write      <= 1'b1;
                    pair_odd   <= 1'b0;
                end else begin
                    low_half <= sample_data;
                    pair_odd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aline_capture_writer.sv
// rtl/aline_capture_writer.sv - per-trigger sample capture into wrapping on-chip RAM
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   enable                level; allows arming and capturing lines
//   trig                  one-cycle sweep trigger
//   sample_valid/_data    16-bit ADC sample stream, no backpressure
//   address               word address of the current write
//   byteenable/writedata  packed write word and its lanes
//   chipselect/write      memory write strobe (identical)
//   clken                 constant 1
//   busy                  high while capturing or flushing a line
//   line_done             one-cycle pulse alongside the final write of a line
//   line_count            completed lines, wraps at 2^16
//   overrun               sticky; trigger seen while a line was in progress
module aline_capture_writer #(
    parameter int SAMPLES_PER_LINE = 1024,
    parameter int DEPTH_WORDS      = aline_capture_pkg::DEPTH_WORDS,
    parameter int ADDR_W           = aline_capture_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trig,
    input  logic              sample_valid,
    input  logic [15:0]       sample_data,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    output logic              busy,
    output logic              line_done,
    output logic [15:0]       line_count,
    output logic              overrun
);

    localparam logic [15:0]       LAST_IDX  = 16'(SAMPLES_PER_LINE - 1);
    localparam logic              SPL_ODD   = 1'(SAMPLES_PER_LINE % 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);

    aline_capture_pkg::state_t state, state_next;

    logic [15:0]       sample_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic              last;
    logic              pair_odd;
    logic              write_next;
    logic              done_next;
    logic              pk_write;

    // A trigger in ARMED with a coincident valid sample makes that sample index 0.
    always_comb begin
        accept = sample_valid &&
                 ((state == aline_capture_pkg::ST_CAPTURE) ||
                  (state == aline_capture_pkg::ST_ARMED && trig));
        last   = accept && (sample_cnt == LAST_IDX);
    end

    always_comb begin
        state_next = state;
        case (state)
            aline_capture_pkg::ST_IDLE: begin
                if (enable)
                    state_next = aline_capture_pkg::ST_ARMED;
            end
            aline_capture_pkg::ST_ARMED: begin
                // last here is only possible with one sample per line (odd).
                if (trig)
                    state_next = last ? aline_capture_pkg::ST_FLUSH
                                      : aline_capture_pkg::ST_CAPTURE;
                else if (!enable)
                    state_next = aline_capture_pkg::ST_IDLE;
            end
            aline_capture_pkg::ST_CAPTURE: begin
                if (last) begin
                    if (SPL_ODD)
                        state_next = aline_capture_pkg::ST_FLUSH;
                    else
                        state_next = enable ? aline_capture_pkg::ST_ARMED
                                            : aline_capture_pkg::ST_IDLE;
                end
            end
            aline_capture_pkg::ST_FLUSH: begin
                state_next = enable ? aline_capture_pkg::ST_ARMED
                                    : aline_capture_pkg::ST_IDLE;
            end
            default: state_next = aline_capture_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        write_next = (accept && pair_odd) || (state == aline_capture_pkg::ST_FLUSH);
        done_next  = (state == aline_capture_pkg::ST_CAPTURE && last && !SPL_ODD) ||
                     (state == aline_capture_pkg::ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= aline_capture_pkg::ST_IDLE;
            sample_cnt <= 16'h0;
            wr_addr    <= '0;
            address    <= '0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
            line_count <= 16'h0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == aline_capture_pkg::ST_CAPTURE) ||
                         (state_next == aline_capture_pkg::ST_FLUSH);
            line_done <= done_next;
            if (done_next)
                line_count <= line_count + 16'd1;
            if (accept)
                sample_cnt <= last ? 16'h0 : sample_cnt + 16'd1;
            // wr_addr points at the next free word; address holds the word being written.
            if (write_next) begin
                address <= wr_addr;
                wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);
            end
            if (trig && (state == aline_capture_pkg::ST_CAPTURE ||
                         state == aline_capture_pkg::ST_FLUSH))
                overrun <= 1'b1;
        end
    end

    sample_pair_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .accept      (accept),
        .flush       (state == aline_capture_pkg::ST_FLUSH),
        .sample_data (sample_data),
        .pair_odd    (pair_odd),
        .write       (pk_write),
        .writedata   (writedata),
        .byteenable  (byteenable)
    );

    assign write      = pk_write;
    assign chipselect = pk_write;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_aline_capture_writer.sv
// tb/tb_aline_capture_writer.sv - scoreboard bench for aline_capture_writer
module tb_aline_capture_writer;

    typedef struct packed {
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        done;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        en  [3];
    logic        tr  [3];
    logic        sv  [3];
    logic [15:0] sd  [3];
    logic [16:0] addr [3];
    logic [3:0]  be  [3];
    logic        cs  [3];
    logic        wr  [3];
    logic [31:0] wd  [3];
    logic        ck  [3];
    logic        bsy [3];
    logic        ld  [3];
    logic [15:0] lc  [3];
    logic        ovr [3];

    wr_t q0[$];
    wr_t q1[$];
    wr_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aline_capture_writer #(.SAMPLES_PER_LINE(8)) dut_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .trig(tr[0]),
        .sample_valid(sv[0]), .sample_data(sd[0]), .address(addr[0]),
        .byteenable(be[0]), .chipselect(cs[0]), .write(wr[0]), .writedata(wd[0]),
        .clken(ck[0]), .busy(bsy[0]), .line_done(ld[0]), .line_count(lc[0]),
        .overrun(ovr[0]));

    aline_capture_writer #(.SAMPLES_PER_LINE(5)) dut_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .trig(tr[1]),
        .sample_valid(sv[1]), .sample_data(sd[1]), .address(addr[1]),
        .byteenable(be[1]), .chipselect(cs[1]), .write(wr[1]), .writedata(wd[1]),
        .clken(ck[1]), .busy(bsy[1]), .line_done(ld[1]), .line_count(lc[1]),
        .overrun(ovr[1]));

    aline_capture_writer #(.SAMPLES_PER_LINE(6), .DEPTH_WORDS(4)) dut_c (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .trig(tr[2]),
        .sample_valid(sv[2]), .sample_data(sd[2]), .address(addr[2]),
        .byteenable(be[2]), .chipselect(cs[2]), .write(wr[2]), .writedata(wd[2]),
        .clken(ck[2]), .busy(bsy[2]), .line_done(ld[2]), .line_count(lc[2]),
        .overrun(ovr[2]));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic fail_event(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    task automatic exp_wr(input int d, input int a, input logic [3:0] b,
                          input logic [31:0] data, input logic done);
        wr_t e;
        e.addr = 17'(a);
        e.be   = b;
        e.data = data;
        e.done = done;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: sample on the falling edge, pop one expectation per write.
    wr_t mon_e;
    bit  mon_has;
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ld[d] && !wr[d])
                fail_event($sformatf("dut%0d line_done without write", d));
            if (wr[d]) begin
                mon_has = 1'b0;
                case (d)
                    0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_has = 1'b1; end
                    1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_has = 1'b1; end
                    default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_has = 1'b1; end
                endcase
                if (!mon_has) begin
                    fail_event($sformatf("dut%0d unexpected write addr %0h data %0h",
                                         d, addr[d], wd[d]));
                end else begin
                    chk($sformatf("dut%0d address", d), 64'(addr[d]), 64'(mon_e.addr));
                    chk($sformatf("dut%0d byteenable", d), 64'(be[d]), 64'(mon_e.be));
                    chk($sformatf("dut%0d writedata", d), 64'(wd[d]), 64'(mon_e.data));
                    chk($sformatf("dut%0d line_done", d), 64'(ld[d]), 64'(mon_e.done));
                    chk($sformatf("dut%0d chipselect", d), 64'(cs[d]), 64'(1'b1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic trig_pulse(input int d);
        tr[d] = 1'b1;
        tick();
        tr[d] = 1'b0;
    endtask

    task automatic sample(input int d, input logic [15:0] v);
        sv[d] = 1'b1;
        sd[d] = v;
        tick();
        sv[d] = 1'b0;
    endtask

    task automatic line(input int d, input int first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample(d, 16'(first + i));
            idle(gap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; tr[d] = 1'b0; sv[d] = 1'b0; sd[d] = 16'h0;
        end
        idle(3);

        chk("reset address", 64'(addr[0]), 64'h0);
        chk("reset write", 64'(wr[0]), 64'h0);
        chk("reset chipselect", 64'(cs[0]), 64'h0);
        chk("reset byteenable", 64'(be[0]), 64'h0);
        chk("reset writedata", 64'(wd[0]), 64'h0);
        chk("reset line_done", 64'(ld[0]), 64'h0);
        chk("reset line_count", 64'(lc[0]), 64'h0);
        chk("reset overrun", 64'(ovr[0]), 64'h0);
        chk("reset busy", 64'(bsy[0]), 64'h0);
        chk("reset clken", 64'(ck[0]), 64'h1);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Even line of 8 samples 1..8.
        en[0] = 1'b1;
        idle(2);
        exp_wr(0, 0, 4'hF, 32'h00020001, 1'b0);
        exp_wr(0, 1, 4'hF, 32'h00040003, 1'b0);
        exp_wr(0, 2, 4'hF, 32'h00060005, 1'b0);
        exp_wr(0, 3, 4'hF, 32'h00080007, 1'b1);
        trig_pulse(0);
        line(0, 1, 8, 0);
        idle(3);
        chk("a line_count after line 1", 64'(lc[0]), 64'd1);
        chk("a busy after line 1", 64'(bsy[0]), 64'd0);

        // trig and valid together in ARMED: 0x11 is sample 0.
        exp_wr(0, 4, 4'hF, 32'h00120011, 1'b0);
        exp_wr(0, 5, 4'hF, 32'h00140013, 1'b0);
        exp_wr(0, 6, 4'hF, 32'h00160015, 1'b0);
        exp_wr(0, 7, 4'hF, 32'h00180017, 1'b1);
        tr[0] = 1'b1; sv[0] = 1'b1; sd[0] = 16'h0011;
        tick();
        tr[0] = 1'b0; sv[0] = 1'b0;
        line(0, 'h12, 7, 0);
        idle(3);
        chk("a line_count after line 2", 64'(lc[0]), 64'd2);

        // Reset after 3 samples: only the completed pair is written.
        exp_wr(0, 8, 4'hF, 32'h00320031, 1'b0);
        trig_pulse(0);
        line(0, 'h31, 3, 0);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("a address after reset", 64'(addr[0]), 64'h0);
        chk("a line_count after reset", 64'(lc[0]), 64'h0);
        chk("a write after reset", 64'(wr[0]), 64'h0);
        chk("a busy after reset", 64'(bsy[0]), 64'h0);

        // enable dropped mid-line: line completes from address 0, then IDLE.
        idle(2);
        exp_wr(0, 0, 4'hF, 32'h00420041, 1'b0);
        exp_wr(0, 1, 4'hF, 32'h00440043, 1'b0);
        exp_wr(0, 2, 4'hF, 32'h00460045, 1'b0);
        exp_wr(0, 3, 4'hF, 32'h00480047, 1'b1);
        trig_pulse(0);
        line(0, 'h41, 4, 0);
        en[0] = 1'b0;
        line(0, 'h45, 4, 0);
        idle(3);
        chk("a busy after disabled line", 64'(bsy[0]), 64'd0);
        chk("a line_count after disabled line", 64'(lc[0]), 64'd1);
        trig_pulse(0);
        line(0, 'h51, 2, 0);
        idle(3);
        chk("a busy after idle trig", 64'(bsy[0]), 64'd0);
        chk("a line_count after idle trig", 64'(lc[0]), 64'd1);

        // Odd line of 5 samples with flush, then a second line.
        en[1] = 1'b1;
        idle(2);
        exp_wr(1, 0, 4'hF, 32'h000B000A, 1'b0);
        exp_wr(1, 1, 4'hF, 32'h000D000C, 1'b0);
        exp_wr(1, 2, 4'h3, 32'h0000000E, 1'b1);
        trig_pulse(1);
        line(1, 'hA, 5, 0);
        idle(3);
        chk("b line_count after line 1", 64'(lc[1]), 64'd1);
        exp_wr(1, 3, 4'hF, 32'h00020001, 1'b0);
        exp_wr(1, 4, 4'hF, 32'h00040003, 1'b0);
        exp_wr(1, 5, 4'h3, 32'h00000005, 1'b1);
        trig_pulse(1);
        line(1, 1, 5, 0);
        idle(3);
        chk("b line_count after line 2", 64'(lc[1]), 64'd2);
        chk("b overrun before retrigger", 64'(ovr[1]), 64'd0);

        // Gapped samples with a second trigger mid-line.
        exp_wr(1, 6, 4'hF, 32'h00220021, 1'b0);
        exp_wr(1, 7, 4'hF, 32'h00240023, 1'b0);
        exp_wr(1, 8, 4'h3, 32'h00000025, 1'b1);
        trig_pulse(1);
        line(1, 'h21, 3, 2);
        trig_pulse(1);
        line(1, 'h24, 2, 2);
        idle(3);
        chk("b overrun after retrigger", 64'(ovr[1]), 64'd1);
        chk("b line_count after gapped line", 64'(lc[1]), 64'd3);

        // Address wrap at depth 4 with 6-sample lines.
        en[2] = 1'b1;
        idle(2);
        exp_wr(2, 0, 4'hF, 32'h00020001, 1'b0);
        exp_wr(2, 1, 4'hF, 32'h00040003, 1'b0);
        exp_wr(2, 2, 4'hF, 32'h00060005, 1'b1);
        trig_pulse(2);
        line(2, 1, 6, 0);
        idle(2);
        exp_wr(2, 3, 4'hF, 32'h00080007, 1'b0);
        exp_wr(2, 0, 4'hF, 32'h000A0009, 1'b0);
        exp_wr(2, 1, 4'hF, 32'h000C000B, 1'b1);
        trig_pulse(2);
        line(2, 7, 6, 0);
        idle(3);
        chk("c line_count after wrap", 64'(lc[2]), 64'd2);

        idle(5);
        chk("a pending writes", 64'(q0.size()), 64'd0);
        chk("b pending writes", 64'(q1.size()), 64'd0);
        chk("c pending writes", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
